// File: rtl/RAM_shared_pkg.sv
// Shared RAM definitions: bus width, RAM command opcodes and arbiter FSM states.
package RAM_shared_pkg;

    localparam int ADDR_SIZE = 8;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } ram_op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        DATA    = 3'd2,
        RD_WAIT = 3'd3,
        ACK     = 3'd4
    } arb_state_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side signal bundle for ram_arbiter; slave is the arbiter side.
interface ram_arbiter_if #(
    parameter int ADDR_SIZE = RAM_shared_pkg::ADDR_SIZE
);
    logic                 req0;
    logic                 req1;
    logic                 we0;
    logic                 we1;
    logic [ADDR_SIZE-1:0] addr0;
    logic [ADDR_SIZE-1:0] addr1;
    logic [ADDR_SIZE-1:0] wdata0;
    logic [ADDR_SIZE-1:0] wdata1;
    logic                 ack0;
    logic                 ack1;
    logic [ADDR_SIZE-1:0] rdata0;
    logic [ADDR_SIZE-1:0] rdata1;
    logic                 rd_err;
    logic [ADDR_SIZE+1:0] ram_din;
    logic                 ram_rx_valid;
    logic [ADDR_SIZE-1:0] ram_dout;
    logic                 ram_tx_valid;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata0, rdata1, rd_err,
        input  ram_din, ram_rx_valid,
        output ram_dout, ram_tx_valid
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata0, rdata1, rd_err,
        output ram_din, ram_rx_valid,
        input  ram_dout, ram_tx_valid
    );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the port that did not win last time wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt_id,
    output logic gnt_valid
);

    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            gnt_id = ~last_gnt;
        end else begin
            gnt_id = req1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter that serialises whole read/write transactions
// into the RAM's two-command sequence and returns read data with a one-cycle ack.
module ram_arbiter #(
    parameter int ADDR_SIZE = RAM_shared_pkg::ADDR_SIZE
) (
    input logic          clk,
    input logic          rst_n,
    ram_arbiter_if.slave bus
);
    import RAM_shared_pkg::*;

    localparam logic [2:0] ST_IDLE    = IDLE;
    localparam logic [2:0] ST_ADDR    = ADDR;
    localparam logic [2:0] ST_DATA    = DATA;
    localparam logic [2:0] ST_RD_WAIT = RD_WAIT;
    localparam logic [2:0] ST_ACK     = ACK;

    logic [2:0]           state;
    logic [2:0]           nxt_state;
    logic                 last_gnt;
    logic                 win_id;
    logic                 gnt_id;
    logic                 gnt_valid;
    logic                 lat_we;
    logic [ADDR_SIZE-1:0] lat_addr;
    logic [ADDR_SIZE-1:0] lat_wdata;
    logic [ADDR_SIZE-1:0] rdata0_q;
    logic [ADDR_SIZE-1:0] rdata1_q;

    function automatic logic [ADDR_SIZE+1:0] cmd(input ram_op_e op,
                                                 input logic [ADDR_SIZE-1:0] payload);
        return {op, payload};
    endfunction

    rr_arb2 u_rr_arb2 (
        .req0      (bus.req0),
        .req1      (bus.req1),
        .last_gnt  (last_gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        nxt_state = state;
        case (state)
            ST_IDLE:    if (gnt_valid) nxt_state = ST_ADDR;
            ST_ADDR:    nxt_state = ST_DATA;
            ST_DATA:    nxt_state = lat_we ? ST_ACK : ST_RD_WAIT;
            ST_RD_WAIT: nxt_state = ST_ACK;
            ST_ACK:     nxt_state = ST_IDLE;
            default:    nxt_state = ST_IDLE;
        endcase
    end

    // Control and read-result registers; async reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            last_gnt <= 1'b1;
            win_id   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state <= nxt_state;
            if (state == ST_IDLE && gnt_valid) begin
                win_id <= gnt_id;
            end
            if (state == ST_ACK) begin
                last_gnt <= win_id;
            end
            // tx_valid is only trusted here; the RAM leaves it high after earlier reads.
            if (state == ST_RD_WAIT && bus.ram_tx_valid) begin
                if (win_id) rdata1_q <= bus.ram_dout;
                else        rdata0_q <= bus.ram_dout;
            end
        end
    end

    // Transaction fields; the command mux masks them outside ADDR/DATA.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && gnt_valid) begin
            lat_we    <= gnt_id ? bus.we1    : bus.we0;
            lat_addr  <= gnt_id ? bus.addr1  : bus.addr0;
            lat_wdata <= gnt_id ? bus.wdata1 : bus.wdata0;
        end
    end

    always_comb begin
        bus.ram_din      = '0;
        bus.ram_rx_valid = 1'b0;
        case (state)
            ST_ADDR: begin
                bus.ram_rx_valid = 1'b1;
                bus.ram_din      = cmd(lat_we ? OP_WR_ADDR : OP_RD_ADDR, lat_addr);
            end
            ST_DATA: begin
                bus.ram_rx_valid = 1'b1;
                bus.ram_din      = cmd(lat_we ? OP_WR_DATA : OP_RD_DATA,
                                       lat_we ? lat_wdata : '0);
            end
            default: ;
        endcase
    end

    assign bus.ack0   = (state == ST_ACK) && !win_id;
    assign bus.ack1   = (state == ST_ACK) && win_id;
    assign bus.rd_err = (state == ST_RD_WAIT) && !bus.ram_tx_valid;
    assign bus.rdata0 = rdata0_q;
    assign bus.rdata1 = rdata1_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and command sequencer in front of the single-port command-driven RAM. It accepts whole read/write transactions from two independent requesters. It serialises each transaction into the RAM's two-command sequence on `din`/`rx_valid`, and returns read data to the winning requester with a one-cycle acknowledge. It sits between the SPI-side/user logic and the RAM instance in the wrapper.

## Interface
- `ADDR_SIZE`, default 8 (from `RAM_shared_pkg`): address and data width of the RAM.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `req0`, `req1` input 1: transaction request; held with fields stable until the matching ack.
- `we0`, `we1` input 1: 1 = write, 0 = read.
- `addr0`, `addr1` input ADDR_SIZE: target address.
- `wdata0`, `wdata1` input ADDR_SIZE: write data (ignored for reads).
- `ack0`, `ack1` output 1: one-cycle completion pulse.
- `rdata0`, `rdata1` output ADDR_SIZE: read result; valid with ack, held until that port's next read ack.
- `rd_err` output 1: one-cycle pulse when the RAM fails to return `tx_valid` for a read.
- `ram_din` output ADDR_SIZE+2: command to RAM, `{opcode[1:0], payload}`.
- `ram_rx_valid` output 1: command strobe to RAM.
- `ram_dout` input ADDR_SIZE: RAM read data.
- `ram_tx_valid` input 1: RAM read-data valid.

## Operation
- Opcodes: 00 = write address, 01 = write data, 10 = read address, 11 = read data.
- Write sends 00+addr, then 01+wdata. Read sends 10+addr, then 11+0.
- FSM states:
  - IDLE: `ram_rx_valid`=0, `ram_din`=0. If any req is high, pick the winner, latch we/addr/wdata and winner id, then go to ADDR.
  - ADDR: `ram_din`={we?00:10, addr}, `ram_rx_valid`=1. Go to DATA.
  - DATA: `ram_din`={we?01:11, we?wdata:0}, `ram_rx_valid`=1. Write goes to ACK; read goes to RD_WAIT.
  - RD_WAIT: `ram_rx_valid`=0. If `ram_tx_valid`=1, latch `ram_dout` into the winner's rdata. Otherwise leave rdata unchanged and pulse `rd_err`. Go to ACK.
  - ACK: winner's ack=1, update the round-robin pointer, go to IDLE.
- Round robin: `last_gnt` resets to 1, so port 0 wins the first tie. On a tie the port ≠ `last_gnt` wins. A single request is granted immediately.
- Requester rule: drop req in the cycle after ack. IDLE samples req only in that cycle, so there is no double-issue.
- Only one transaction is in flight at a time. Requests arriving mid-transaction wait in IDLE arbitration.
- `ram_tx_valid` is ignored outside RD_WAIT. The RAM holds it high after a read, and that must not be mistaken for new data.

## Timing
- Reset values: all outputs 0; state IDLE; `last_gnt`=1; rdata0/1=0.
- `rst_n` asserted mid-transaction:
  - returns to IDLE at once;
  - `ram_rx_valid` drops asynchronously;
  - the transaction is dropped with no ack;
  - the requester must reissue.
- Write latency: req seen in IDLE at cycle 0, ADDR in 1, DATA in 2, ack in 3. Back-to-back writes take 4 cycles per transaction.
- Read latency: cycle 0 IDLE, 1 ADDR, 2 DATA, 3 RD_WAIT (sample `ram_dout`), ack and rdata valid in 4. Read occupancy is 5 cycles.
- `ram_rx_valid` is high for exactly 2 consecutive cycles per transaction.

## Structure
- Add the following to `RAM_shared_pkg`:
  - opcode enum `ram_op_e` {OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11};
  - state enum `arb_state_e` {IDLE, ADDR, DATA, RD_WAIT, ACK}.
- Sub-module `rr_arb2`: combinational two-way round-robin pick from req0/req1 and `last_gnt`, producing a grant id plus a valid flag. The FSM, latches and command mux stay in the top module.

## Test plan
- Port 0 writes addr 0x12 data 0xA5, port 1 idle -> `ram_din` 0x012 then 0x1A5 on cycles 1–2, ack0 in cycle 3, ack1 never.
- Port 1 reads addr 0x12 after that write, with the real RAM attached -> `ram_din` 0x212 then 0x300, ack1 in cycle 4, rdata1=0xA5.
- req0 and req1 both high from reset, both reads -> port 0 served first. Port 1 is granted the IDLE cycle after ack0, and no third grant occurs.
- Port 0 requests continuously while port 1 requests once -> grants alternate 0, 1, 0. Port 1 waits at most one transaction.
- RAM model forces `ram_tx_valid`=0 in RD_WAIT -> `rd_err` pulses one cycle, ack still issued, rdata keeps its previous value.
- `rst_n` pulsed low during DATA of a write -> `ram_rx_valid` drops immediately, no ack. The next request restarts from IDLE, with port 0 winning the tie.
